interval_timer_ctrl: RTL and testbench

INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

---
 rtl/timer_pkg.sv | 16 +
 rtl/down_counter_core.sv | 36 +++
 rtl/interval_timer_ctrl.sv | 158 +++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer.
//   WIDTH_DEFAULT : default counter / reload width in bits
//   state_t       : controller state encoding (IDLE, LOAD, RUN, DONE)
package timer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  // Binary state encoding used by the timer controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : timer_pkg

// File: rtl/down_counter_core.sv
// Loadable down-counter that saturates at zero.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears q
//   load  : load din into q (has priority over en)
//   en    : decrement q by one when q is non-zero
//   din   : value loaded on load
//   q     : current counter value
//   zero  : high when q == 0
module down_counter_core
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  // Counter register; a decrement request at zero holds rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (en && !zero) begin
      q <= q - WIDTH'(1);
    end
  end

  assign zero = (q == '0);

endmodule : down_counter_core

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: one-shot or auto-reload countdown with a
// registered terminal-count pulse.
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   start      : latch reload_val/periodic and begin a run (IDLE or DONE only)
//   stop       : abort a run, or leave DONE; wins over start and over tc
//   reload_val : terminal interval, sampled on an accepted start
//   periodic   : 1 = auto-reload, 0 = one-shot, sampled on an accepted start
//   count      : current counter value
//   busy       : high in LOAD and RUN
//   tc         : one-cycle terminal-count pulse
//   done       : high in DONE
//   err        : sticky, set by a start while busy, cleared by accepted start
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] reload_val,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             err
);

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] reload_q;
  logic             periodic_q;
  logic             cfg_latch;

  logic             tc_d;
  logic             err_d;

  logic             ctr_load;
  logic             ctr_en;
  logic [WIDTH-1:0] ctr_din;
  logic             ctr_zero;

  // Counting datapath.
  down_counter_core #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .load  (ctr_load),
    .en    (ctr_en),
    .din   (ctr_din),
    .q     (count),
    .zero  (ctr_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration latched only on an accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reload_q   <= '0;
      periodic_q <= 1'b0;
    end else if (cfg_latch) begin
      reload_q   <= reload_val;
      periodic_q <= periodic;
    end
  end

  // Terminal-count pulse and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tc  <= 1'b0;
      err <= 1'b0;
    end else begin
      tc  <= tc_d;
      err <= err_d;
    end
  end

  // Next-state, counter control and flag logic.
  always_comb begin
    state_d   = state_q;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    ctr_din   = '0;
    cfg_latch = 1'b0;
    tc_d      = 1'b0;
    err_d     = err;

    case (state_q)
      IDLE, DONE: begin
        // stop outranks start; the counter is already zero here.
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d   = LOAD;
          ctr_load  = 1'b1;
          ctr_din   = reload_val;
          cfg_latch = 1'b1;
          err_d     = 1'b0;
        end
      end

      LOAD: begin
        if (start) begin
          err_d = 1'b1;
        end
        if (stop) begin
          state_d  = IDLE;
          ctr_load = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (start) begin
          err_d = 1'b1;
        end
        // Abort clears the count and suppresses a tc due this cycle.
        if (stop) begin
          state_d  = IDLE;
          ctr_load = 1'b1;
        end else if (ctr_zero) begin
          tc_d = 1'b1;
          if (periodic_q) begin
            ctr_load = 1'b1;
            ctr_din  = reload_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          ctr_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status decoded from the state register only.
  assign busy = (state_q == LOAD) || (state_q == RUN);
  assign done = (state_q == DONE);

endmodule : interval_timer_ctrl

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: directed scenarios followed by
// random start/stop traffic, compared against an arithmetic reference model.
module tb_interval_timer_ctrl;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] reload_val = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;
  logic         err;

  interval_timer_ctrl #(
    .WIDTH (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .reload_val (reload_val),
    .periodic   (periodic),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a run is described by k = rising edges since the start
  // was accepted, the latched interval m_r and mode m_per.
  // m_mode: 0 idle, 1 running (LOAD/RUN), 2 done.
  int m_mode = 0;
  int m_k    = 0;
  int m_r    = 0;
  bit m_per  = 1'b0;
  bit m_err  = 1'b0;
  bit m_tc   = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_count();
    if (m_mode != 1) return 0;
    if (m_k == 0) return m_r;
    if (m_per) return m_r - ((m_k - 1) % (m_r + 1));
    return m_r - (m_k - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_r    = 0;
    m_per  = 1'b0;
    m_err  = 1'b0;
    m_tc   = 1'b0;
  endtask

  // One rising edge with the given sampled inputs.
  task automatic model_step(input bit st, input bit sp, input int rv, input bit pv);
    m_tc = 1'b0;
    if (m_mode == 1) begin
      if (st) m_err = 1'b1;
      if (sp) begin
        m_mode = 0;
      end else begin
        m_k++;
        // First tc R+2 edges after start, then every R+1 edges when periodic.
        if (m_k >= m_r + 2 && ((m_k - (m_r + 2)) % (m_r + 1)) == 0) m_tc = 1'b1;
        if (!m_per && m_k == m_r + 2) m_mode = 2;
      end
    end else begin
      if (sp) begin
        m_mode = 0;
      end else if (st) begin
        m_mode = 1;
        m_k    = 0;
        m_r    = rv;
        m_per  = pv;
        m_err  = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " count"}, int'(count), exp_count());
    check({tag, " busy"},  int'(busy),  int'(m_mode == 1));
    check({tag, " done"},  int'(done),  int'(m_mode == 2));
    check({tag, " tc"},    int'(tc),    int'(m_tc));
    check({tag, " err"},   int'(err),   int'(m_err));
  endtask

  task automatic do_cycle(input string tag, input bit st, input bit sp,
                          input int rv, input bit pv);
    @(negedge clock);
    start      = st;
    stop       = sp;
    reload_val = W'(rv);
    periodic   = pv;
    @(posedge clock);
    model_step(st, sp, rv, pv);
    #1;
    check_all(tag);
  endtask

  initial begin
    int tc_seen;
    model_reset();

    // Reset held low, then 20 idle cycles.
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) do_cycle("idle", 1'b0, 1'b0, 0, 1'b0);

    // One-shot, reload 5.
    do_cycle("os5", 1'b1, 1'b0, 5, 1'b0);
    for (int i = 0; i < 9; i++) do_cycle("os5", 1'b0, 1'b0, 9, 1'b1);

    // Periodic, reload 3: five periods, then stop.
    tc_seen = 0;
    do_cycle("per3", 1'b1, 1'b0, 3, 1'b1);
    for (int i = 0; i < 21; i++) begin
      do_cycle("per3", 1'b0, 1'b0, 0, 1'b0);
      if (tc) tc_seen++;
    end
    check("per3 tc pulses", tc_seen, 5);
    do_cycle("per3 stop", 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 6; i++) do_cycle("per3 after", 1'b0, 1'b0, 0, 1'b0);

    // Stop in the cycle count reaches zero (reload 2, one-shot).
    do_cycle("stopz", 1'b1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle("stopz", 1'b0, 1'b0, 0, 1'b0);
    check("stopz count at zero", int'(count), 0);
    do_cycle("stopz stop", 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle("stopz after", 1'b0, 1'b0, 0, 1'b0);

    // Start while busy sets err; restart from DONE clears it.
    do_cycle("err6", 1'b1, 1'b0, 6, 1'b0);
    do_cycle("err6", 1'b0, 1'b0, 0, 1'b0);
    do_cycle("err6 busy start", 1'b1, 1'b0, 1, 1'b1);
    for (int i = 0; i < 8; i++) do_cycle("err6", 1'b0, 1'b0, 0, 1'b0);
    do_cycle("err6 restart", 1'b1, 1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle("err6", 1'b0, 1'b0, 0, 1'b0);

    // Simultaneous start and stop from DONE and from IDLE: stop wins.
    do_cycle("ss done", 1'b1, 1'b1, 3, 1'b0);
    do_cycle("ss idle", 1'b1, 1'b1, 3, 1'b0);

    // Asynchronous reset mid-run at count 2, then reload 0 one-shot.
    do_cycle("rst", 1'b1, 1'b0, 4, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle("rst", 1'b0, 1'b0, 0, 1'b0);
    check("rst count before", int'(count), 2);
    @(negedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("rst async");
    #1;
    reset = 1'b1;
    do_cycle("rst idle", 1'b0, 1'b0, 0, 1'b0);
    do_cycle("r0", 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle("r0", 1'b0, 1'b0, 0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bit st;
      bit sp;
      st = ($urandom % 8) == 0;
      sp = ($urandom % 14) == 0;
      if (m_mode == 1 && sp) st = 1'b0;
      do_cycle("rand", st, sp, int'($urandom % 16), bit'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_interval_timer_ctrl
